// File: rtl/wave_pkg.sv
// Shared wave geometry, bank-select type and modular column arithmetic.
// Defining WAVE_BUFFER_PREV_EN adds a third bank that holds the previous profile.
package wave_pkg;

  localparam int LOG_WIDTH = 10;
  localparam int WIDTH     = 1024;
  localparam int RESOL     = 10;

`ifdef WAVE_BUFFER_PREV_EN
  localparam int NUM_BANKS = 3;
  localparam int RD_PORTS  = 2;
`else
  localparam int NUM_BANKS = 2;
  localparam int RD_PORTS  = 1;
`endif

  localparam int RAM_DEPTH = NUM_BANKS * WIDTH;
  localparam int RAM_AW    = $clog2(RAM_DEPTH);

  localparam logic [LOG_WIDTH:0] WIDTH_EXT = (LOG_WIDTH + 1)'(WIDTH);

  typedef logic [1:0]           bank_t;
  typedef logic [LOG_WIDTH-1:0] col_t;
  typedef logic [RAM_AW-1:0]    ram_addr_t;

  // (a + b) mod WIDTH for a, b < WIDTH: one extra carry bit, then a single subtract.
  function automatic col_t mod_add_width(input col_t a, input col_t b);
    logic [LOG_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= WIDTH_EXT) begin
      sum = sum - WIDTH_EXT;
    end
    return sum[LOG_WIDTH-1:0];
  endfunction

  function automatic ram_addr_t bank_addr(input bank_t bank, input col_t col);
    return ram_addr_t'(bank) * ram_addr_t'(WIDTH) + ram_addr_t'(col);
  endfunction

endpackage

// File: rtl/wave_bank_ram.sv
// Banked sample store: one write port, RD_PORTS synchronous read ports sharing
// a read enable. Output registers hold their value while i_re is low.
module wave_bank_ram #(
  parameter int DEPTH    = 2048,
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 10,
  parameter int RD_PORTS = 1
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr [RD_PORTS],
  output logic [DATA_W-1:0] o_rdata [RD_PORTS]
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  generate
    for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd
      logic [DATA_W-1:0] r_q;
      always_ff @(posedge clock) begin
        if (i_re) begin
          r_q <= r_mem[i_raddr[gi]];
        end
      end
      assign o_rdata[gi] = r_q;
    end
  endgenerate

endmodule

// File: rtl/wave_buffer.sv
// Double-buffered wave profile store: captures into the back bank, swaps at a
// frame boundary, serves scrolled reads. Optional macro: WAVE_BUFFER_PREV_EN.
module wave_buffer
  import wave_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic [LOG_WIDTH-1:0] sample_index,
  input  logic [RESOL-1:0]     sample_value,
  input  logic                 wave_ready,
  input  logic                 frame_start,
  input  logic [LOG_WIDTH-1:0] scroll_step,
  input  logic                 rd_en,
  input  logic [LOG_WIDTH-1:0] rd_index,
  output logic [RESOL-1:0]     rd_value,
  output logic                 rd_valid,
  output logic                 wave_valid,
  output logic                 swap_pending,
  output logic                 overrun,
  output logic [RESOL-1:0]     prev_value
);

  bank_t     r_front;
  bank_t     w_back;
  col_t      r_offset;
  col_t      w_rd_col;
  logic      r_rd_valid;
  logic      r_rd_gate;
  logic      r_wave_valid;
  logic      r_swap_pending;
  logic      r_overrun;
  logic      w_swap;
  logic      w_write;
  ram_addr_t w_waddr;
  ram_addr_t w_raddr [RD_PORTS];
  logic [RESOL-1:0] w_rdata [RD_PORTS];

  assign w_swap   = frame_start & (r_swap_pending | wave_ready);
  assign w_write  = sample_valid & ~r_swap_pending & ({1'b0, sample_index} < WIDTH_EXT);
  assign w_waddr  = bank_addr(w_back, sample_index);
  assign w_rd_col = mod_add_width(rd_index, r_offset);
  assign w_raddr[0] = bank_addr(r_front, w_rd_col);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_offset       <= '0;
      r_rd_valid     <= 1'b0;
      r_rd_gate      <= 1'b0;
      r_wave_valid   <= 1'b0;
      r_swap_pending <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      if (frame_start) begin
        r_offset <= mod_add_width(r_offset, scroll_step);
      end
      if (w_swap) begin
        r_swap_pending <= 1'b0;
        r_wave_valid   <= 1'b1;
      end else if (wave_ready) begin
        r_swap_pending <= 1'b1;
      end
      if (sample_valid & r_swap_pending) begin
        r_overrun <= 1'b1;
      end
      r_rd_valid <= rd_en;
      // The RAM output register cannot be reset, so a resettable gate masks it.
      if (rd_en) begin
        r_rd_gate <= r_wave_valid;
      end
    end
  end

`ifdef WAVE_BUFFER_PREV_EN
  bank_t r_back;
  bank_t r_prev;
  logic  r_prev_valid;
  logic  r_prev_gate;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_front      <= 2'd0;
      r_back       <= 2'd1;
      r_prev       <= 2'd2;
      r_prev_valid <= 1'b0;
      r_prev_gate  <= 1'b0;
    end else begin
      if (w_swap) begin
        r_prev       <= r_front;
        r_front      <= r_back;
        r_back       <= r_prev;
        r_prev_valid <= r_prev_valid | r_wave_valid;
      end
      if (rd_en) begin
        r_prev_gate <= r_prev_valid;
      end
    end
  end

  assign w_back     = r_back;
  assign w_raddr[1] = bank_addr(r_prev, w_rd_col);
  assign prev_value = r_prev_gate ? w_rdata[1] : '0;
`else
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_front <= 2'd0;
    end else if (w_swap) begin
      r_front <= w_back;
    end
  end

  assign w_back     = {1'b0, ~r_front[0]};
  assign prev_value = '0;
`endif

  wave_bank_ram #(
    .DEPTH    (RAM_DEPTH),
    .ADDR_W   (RAM_AW),
    .DATA_W   (RESOL),
    .RD_PORTS (RD_PORTS)
  ) u_ram (
    .clock   (clock),
    .i_we    (w_write),
    .i_waddr (w_waddr),
    .i_wdata (sample_value),
    .i_re    (rd_en),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign rd_value     = r_rd_gate ? w_rdata[0] : '0;
  assign rd_valid     = r_rd_valid;
  assign wave_valid   = r_wave_valid;
  assign swap_pending = r_swap_pending;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_wave_buffer.sv
// Directed bench for wave_buffer: reset, capture/swap, scroll wrap, overrun,
// same-cycle swap and asynchronous mid-stream reset.
module tb_wave_buffer;

  logic       clock;
  logic       reset;
  logic       sample_valid;
  logic [9:0] sample_index;
  logic [9:0] sample_value;
  logic       wave_ready;
  logic       frame_start;
  logic [9:0] scroll_step;
  logic       rd_en;
  logic [9:0] rd_index;
  logic [9:0] rd_value;
  logic       rd_valid;
  logic       wave_valid;
  logic       swap_pending;
  logic       overrun;
  logic [9:0] prev_value;

  int errors = 0;
  int checks = 0;

  wave_buffer dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_index (sample_index),
    .sample_value (sample_value),
    .wave_ready   (wave_ready),
    .frame_start  (frame_start),
    .scroll_step  (scroll_step),
    .rd_en        (rd_en),
    .rd_index     (rd_index),
    .rd_value     (rd_value),
    .rd_valid     (rd_valid),
    .wave_valid   (wave_valid),
    .swap_pending (swap_pending),
    .overrun      (overrun),
    .prev_value   (prev_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       fs;
    logic [9:0] step;
    logic [9:0] idx;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [9:0] wave_fn(input int mode, input int i);
    logic [9:0] v;
    v = 10'(i);
    case (mode)
      0:       return v;
      1:       return 10'(1023 - i);
      default: return v ^ 10'h155;
    endcase
  endfunction

  task automatic stream(input int mode, input int count);
    for (int i = 0; i < count; i++) begin
      sample_valid = 1'b1;
      sample_index = 10'(i);
      sample_value = wave_fn(mode, i);
      tick();
    end
    sample_valid = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] idx);
    rd_en    = 1'b1;
    rd_index = idx;
    tick();
    rd_en    = 1'b0;
  endtask

  initial begin
    reset = 1'b1;  sample_valid = 1'b0; sample_index = '0; sample_value = '0;
    wave_ready = 1'b0; frame_start = 1'b0; scroll_step = '0;
    rd_en = 1'b0;  rd_index = '0;

    // offset after each frame_start: 0,10,20,20,20,19,0,0,0
    vecs[0] = '{1'b0, 10'd0,    10'd300,  10'd300};
    vecs[1] = '{1'b1, 10'd10,   10'd0,    10'd10};
    vecs[2] = '{1'b1, 10'd10,   10'd1010, 10'd6};
    vecs[3] = '{1'b0, 10'd0,    10'd1003, 10'd1023};
    vecs[4] = '{1'b0, 10'd0,    10'd1004, 10'd0};
    vecs[5] = '{1'b1, 10'd1023, 10'd0,    10'd19};
    vecs[6] = '{1'b1, 10'd1005, 10'd0,    10'd0};
    vecs[7] = '{1'b0, 10'd0,    10'd1023, 10'd1023};
    vecs[8] = '{1'b1, 10'd0,    10'd500,  10'd500};

    #3;
    check("rst_rd_value",     32'(rd_value),     0);
    check("rst_rd_valid",     32'(rd_valid),     0);
    check("rst_wave_valid",   32'(wave_valid),   0);
    check("rst_swap_pending", 32'(swap_pending), 0);
    check("rst_overrun",      32'(overrun),      0);
    check("rst_prev_value",   32'(prev_value),   0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Read before any profile: masked to zero.
    do_read(10'd5);
    check("empty_rd_value",   32'(rd_value),   0);
    check("empty_rd_valid",   32'(rd_valid),   1);
    check("empty_wave_valid", 32'(wave_valid), 0);
    $display("txn empty read idx=5 value=%0d valid=%0d", rd_value, rd_valid);
    tick();
    check("idle_rd_valid", 32'(rd_valid), 0);

    // Profile 1: value = index.
    stream(0, 1024);
    wave_ready = 1'b1; tick(); wave_ready = 1'b0;
    check("p1_pending",      32'(swap_pending), 1);
    check("p1_wave_invalid", 32'(wave_valid),   0);
    frame_start = 1'b1; scroll_step = 10'd0; tick(); frame_start = 1'b0;
    check("p1_wave_valid",   32'(wave_valid),   1);
    check("p1_pending_clr",  32'(swap_pending), 0);

    // Scroll/read table; frame_starts here have nothing pending and must not swap.
    for (int k = 0; k < 9; k++) begin
      if (vecs[k].fs) begin
        frame_start = 1'b1;
        scroll_step = vecs[k].step;
        tick();
        frame_start = 1'b0;
        check("vec_no_swap_pending", 32'(swap_pending), 0);
      end
      do_read(vecs[k].idx);
      check("vec_rd_value", 32'(rd_value), 32'(vecs[k].exp));
      check("vec_rd_valid", 32'(rd_valid), 1);
      $display("txn vec %0d fs=%0d step=%0d idx=%0d value=%0d exp=%0d",
               k, vecs[k].fs, vecs[k].step, vecs[k].idx, rd_value, vecs[k].exp);
      tick();
      check("vec_hold_value", 32'(rd_value), 32'(vecs[k].exp));
      check("vec_hold_valid", 32'(rd_valid), 0);
    end

    // Profile 2 plus a dropped third-profile sample.
    stream(1, 1024);
    wave_ready = 1'b1; tick(); wave_ready = 1'b0;
    check("p2_no_overrun", 32'(overrun), 0);
    sample_valid = 1'b1; sample_index = 10'd0; sample_value = 10'd555; tick();
    sample_valid = 1'b0;
    check("p2_overrun", 32'(overrun), 1);
    frame_start = 1'b1; scroll_step = 10'd0; tick(); frame_start = 1'b0;
    check("p2_pending_clr", 32'(swap_pending), 0);
    do_read(10'd0);
    check("p2_idx0", 32'(rd_value), 1023);
    $display("txn p2 read idx=0 value=%0d", rd_value);
    do_read(10'd1023);
    check("p2_idx1023", 32'(rd_value), 0);
    do_read(10'd512);
    check("p2_idx512", 32'(rd_value), 511);
    check("p2_overrun_sticky", 32'(overrun), 1);

    // Profile 3 with wave_ready and frame_start coinciding.
    stream(2, 1024);
    wave_ready = 1'b1; frame_start = 1'b1; rd_en = 1'b1; rd_index = 10'd7;
    tick();
    wave_ready = 1'b0; frame_start = 1'b0;
    check("same_cycle_pending", 32'(swap_pending), 0);
    check("same_cycle_old_front", 32'(rd_value), 1016);
    $display("txn same-cycle swap read idx=7 value=%0d", rd_value);
    tick();
    rd_en = 1'b0;
    check("same_cycle_new_front", 32'(rd_value), 32'(10'd7 ^ 10'h155));
    $display("txn post-swap read idx=7 value=%0d", rd_value);

    // Asynchronous reset in the middle of profile 4 with a read in flight.
    rd_en = 1'b1; rd_index = 10'd1;
    stream(0, 512);
    check("pre_rst_rd_value", 32'(rd_value), 32'(10'd1 ^ 10'h155));
    check("pre_rst_rd_valid", 32'(rd_valid), 1);
    #2 reset = 1'b1;
    #1;
    check("arst_rd_value",     32'(rd_value),     0);
    check("arst_rd_valid",     32'(rd_valid),     0);
    check("arst_wave_valid",   32'(wave_valid),   0);
    check("arst_overrun",      32'(overrun),      0);
    check("arst_swap_pending", 32'(swap_pending), 0);
    $display("txn async reset mid-stream value=%0d valid=%0d", rd_value, rd_valid);
    rd_en = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    do_read(10'd300);
    check("post_rst_rd_value", 32'(rd_value), 0);
    check("post_rst_rd_valid", 32'(rd_valid), 1);
    stream(0, 1024);
    wave_ready = 1'b1; tick(); wave_ready = 1'b0;
    frame_start = 1'b1; scroll_step = 10'd0; tick(); frame_start = 1'b0;
    do_read(10'd300);
    check("post_rst_reload", 32'(rd_value), 300);
    $display("txn reload read idx=300 value=%0d", rd_value);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
